// File: rtl/packet_injector_pkg.sv
// packet_injector_pkg: flit encodings, FSM states and header layout shared by the injector, arbiter and timer.
package packet_injector_pkg;
  localparam logic [2:0] FLIT_NONE   = 3'b000;
  localparam logic [2:0] FLIT_HEADER = 3'b001;
  localparam logic [2:0] FLIT_BODY   = 3'b010;
  localparam logic [2:0] FLIT_TAIL   = 3'b100;
  localparam int LEN_W = 12;
  localparam int DST_W = 4;
  localparam int HDR_W = LEN_W + DST_W;
  typedef enum logic [1:0] {IDLE, ARB, SEND} state_t;
  // A packet always needs at least a header and a tail.
  function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] len);
    return len < LEN_W'(2) ? LEN_W'(2) : len;
  endfunction
  // Header fields occupy the top of the flit word, length above destination.
  function automatic logic [HDR_W-1:0] header_fields(input logic [LEN_W-1:0] len, input logic [DST_W-1:0] dst);
    return {len, dst};
  endfunction
endpackage

// File: rtl/packet_injector_credit_counter.sv
// credit_counter: tracks free downstream slots, saturating at CREDITS.
module credit_counter #(
  parameter int CREDITS = 4,
  parameter int CW = $clog2(CREDITS + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          inc,
  input  logic          dec,
  output logic          avail,
  output logic [CW-1:0] count
);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) count <= CW'(CREDITS);
    else if (dec && !inc) count <= count - CW'(1);
    else if (inc && !dec && count != CW'(CREDITS)) count <= count + CW'(1);
  end
  assign avail = count != '0;
endmodule

// File: rtl/packet_injector.sv
// packet_injector: turns a packet request plus payload stream into header/body/tail flits under arbitration and credits.
module packet_injector
  import packet_injector_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int CREDITS = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pkt_start,
  input  logic [DST_W-1:0]  pkt_dst,
  input  logic [LEN_W-1:0]  pkt_len,
  output logic              pkt_ready,
  input  logic [DATA_W-1:0] pay_data,
  input  logic              pay_valid,
  output logic              pay_ready,
  output logic              req,
  input  logic              grant,
  output logic [2:0]        flit_id,
  output logic [LEN_W-1:0]  length,
  output logic [DATA_W-1:0] flit_data,
  output logic              flit_valid,
  input  logic              credit_in
);
  localparam int CW = $clog2(CREDITS + 1);
  state_t state, state_n;
  logic [LEN_W-1:0] idx;
  logic [DST_W-1:0] dst;
  logic [CW-1:0] credits;
  logic avail, send, last, accept;
  credit_counter #(.CREDITS(CREDITS), .CW(CW)) u_credits (
    .clk(clk), .rst(rst), .inc(credit_in), .dec(send), .avail(avail), .count(credits)
  );
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else state <= state_n;
  end
  always_comb begin
    accept = state == IDLE && pkt_start;
    last = idx == length - LEN_W'(1);
    send = state == SEND && grant && avail && (idx == '0 || pay_valid);
    state_n = state == IDLE ? (pkt_start ? ARB : IDLE)
            : state == ARB  ? (grant ? SEND : ARB)
            : (send && last ? IDLE : SEND);
  end
  assign pkt_ready = state == IDLE;
  assign pay_ready = send && idx != '0;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req <= 1'b0;
      flit_valid <= 1'b0;
      flit_id <= FLIT_NONE;
      flit_data <= '0;
      length <= '0;
      dst <= '0;
      idx <= '0;
    end else begin
      req <= state_n != IDLE;
      flit_valid <= send;
      flit_id <= !send ? FLIT_NONE : idx == '0 ? FLIT_HEADER : last ? FLIT_TAIL : FLIT_BODY;
      flit_data <= !send ? '0 : idx == '0 ? {header_fields(length, dst), {(DATA_W-HDR_W){1'b0}}} : pay_data;
      if (accept) begin
        length <= clamp_len(pkt_len);
        dst <= pkt_dst;
        idx <= '0;
      end else if (send) idx <= idx + LEN_W'(1);
    end
  end
  credits_bounded: assert property (@(posedge clk) disable iff (rst) credits <= CW'(CREDITS));
endmodule

// File: tb/tb_packet_injector.sv
// tb_packet_injector: table-driven packets plus corner-case sequences, checked by a flit scoreboard.
module tb_packet_injector;
  typedef struct {logic [2:0] id; logic [31:0] data;} flit_t;
  typedef struct {logic [11:0] len; logic [3:0] dst; logic [11:0] exp_len;} vec_t;
  logic clk = 0, rst = 0;
  logic pkt_start = 0, pay_valid = 1, grant = 0, credit_in;
  logic [3:0] pkt_dst = 0;
  logic [11:0] pkt_len = 0;
  logic [31:0] pay_data, pay_cnt = 32'h1000;
  logic pkt_ready, pay_ready, req, flit_valid;
  logic [2:0] flit_id;
  logic [11:0] length;
  logic [31:0] flit_data;
  logic auto_credit = 1, cr_auto = 0, cr_man = 0;
  int ncmp = 0, nerr = 0, nflits = 0;
  flit_t q[$];
  vec_t vecs[6];

  packet_injector #(.DATA_W(32), .CREDITS(4)) dut (
    .clk(clk), .rst(rst), .pkt_start(pkt_start), .pkt_dst(pkt_dst), .pkt_len(pkt_len),
    .pkt_ready(pkt_ready), .pay_data(pay_data), .pay_valid(pay_valid), .pay_ready(pay_ready),
    .req(req), .grant(grant), .flit_id(flit_id), .length(length), .flit_data(flit_data),
    .flit_valid(flit_valid), .credit_in(credit_in)
  );

  always #5 clk = ~clk;
  assign pay_data = pay_cnt;
  assign credit_in = (auto_credit & cr_auto) | cr_man;

  always @(posedge clk) if (pay_ready && pay_valid) pay_cnt <= pay_cnt + 1;
  always @(negedge clk) cr_auto = flit_valid && !rst;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    ncmp++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic expire(input string nm);
    ncmp++;
    nerr++;
    $display("FAIL %s: timed out (t=%0t)", nm, $time);
  endtask

  // Scoreboard: every observed flit must match the oldest expected one.
  always @(negedge clk) begin
    if (!rst && flit_valid) begin
      nflits++;
      if (q.size() == 0) begin
        ncmp++;
        nerr++;
        $display("FAIL unexpected_flit: got id %b data %0h, want none", flit_id, flit_data);
      end else begin
        flit_t e;
        e = q.pop_front();
        chk("flit_id", 64'(flit_id), 64'(e.id));
        chk("flit_data", 64'(flit_data), 64'(e.data));
        if (e.id == 3'b100) chk("req_at_tail", 64'(req), 64'(0));
      end
    end
  end

  task automatic start_pkt(input logic [11:0] len, input logic [3:0] dst, input logic [11:0] elen);
    @(negedge clk);
    chk("pkt_ready_idle", 64'(pkt_ready), 64'(1));
    pkt_start = 1;
    pkt_len = len;
    pkt_dst = dst;
    q.push_back('{3'b001, {elen, dst, 16'h0000}});
    for (int i = 1; i < int'(elen); i++)
      q.push_back('{(i == int'(elen) - 1) ? 3'b100 : 3'b010, pay_cnt + 32'(i - 1)});
    @(negedge clk);
    pkt_start = 0;
    chk("length_latch", 64'(length), 64'(elen));
    chk("pkt_ready_busy", 64'(pkt_ready), 64'(0));
  endtask

  task automatic drain();
    for (int i = 0; i < 200 && q.size() != 0; i++) @(negedge clk);
    if (q.size() != 0) begin
      expire("drain");
      q.delete();
    end
    @(negedge clk);
    chk("req_idle", 64'(req), 64'(0));
    chk("pkt_ready_done", 64'(pkt_ready), 64'(1));
  endtask

  task automatic wait_flit();
    for (int i = 0; i < 30 && !flit_valid; i++) @(negedge clk);
    if (!flit_valid) expire("wait_flit");
  endtask

  task automatic pulse_credits(input int n);
    @(negedge clk);
    cr_man = 1;
    repeat (n) @(negedge clk);
    cr_man = 0;
  endtask

  initial begin
    logic [31:0] p0;
    int n0;
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] p0;
    int n0;
    vecs[0] = '{12'd4, 4'd3, 12'd4};
    vecs[1] = '{12'd1, 4'd5, 12'd2};
    vecs[2] = '{12'd0, 4'd9, 12'd2};
    vecs[3] = '{12'd2, 4'd1, 12'd2};
    vecs[4] = '{12'd7, 4'd15, 12'd7};
    vecs[5] = '{12'd3, 4'd0, 12'd3};

    #2 rst = 1;
    #1;
    chk("rst_req", 64'(req), 64'(0));
    chk("rst_flit_valid", 64'(flit_valid), 64'(0));
    chk("rst_flit_id", 64'(flit_id), 64'(0));
    chk("rst_flit_data", 64'(flit_data), 64'(0));
    chk("rst_length", 64'(length), 64'(0));
    chk("rst_pkt_ready", 64'(pkt_ready), 64'(1));
    repeat (2) @(negedge clk);
    rst = 0;

    // Base packet: grant arrives two cycles after the request.
    p0 = pay_cnt;
    start_pkt(12'd4, 4'd3, 12'd4);
    repeat (2) begin
      @(negedge clk);
      chk("arb_req", 64'(req), 64'(1));
      chk("arb_no_flit", 64'(flit_valid), 64'(0));
    end
    grant = 1;
    wait_flit();
    for (int k = 0; k < 4; k++) begin
      if (k > 0) @(negedge clk);
      chk("base_consecutive", 64'(flit_valid), 64'(1));
    end
    chk("base_req_after_tail", 64'(req), 64'(0));
    drain();
    chk("base_payload_words", 64'(pay_cnt - p0), 64'(3));

    foreach (vecs[i]) begin
      p0 = pay_cnt;
      start_pkt(vecs[i].len, vecs[i].dst, vecs[i].exp_len);
      drain();
      chk("vec_payload_words", 64'(pay_cnt - p0), 64'(vecs[i].exp_len - 1));
    end

    // Grant loss after the header.
    start_pkt(12'd5, 4'd10, 12'd5);
    wait_flit();
    chk("gl_header", 64'(flit_id), 64'(3'b001));
    grant = 0;
    repeat (3) begin
      @(negedge clk);
      chk("gl_no_flit", 64'(flit_valid), 64'(0));
      chk("gl_req_held", 64'(req), 64'(1));
    end
    grant = 1;
    drain();

    // Credit starvation: no returns, four flits then one per credit.
    auto_credit = 0;
    repeat (4) @(negedge clk);
    n0 = nflits;
    start_pkt(12'd6, 4'd2, 12'd6);
    repeat (12) @(negedge clk);
    chk("starve_4_flits", 64'(nflits - n0), 64'(4));
    chk("starve_req", 64'(req), 64'(1));
    pulse_credits(1);
    repeat (4) @(negedge clk);
    chk("starve_5_flits", 64'(nflits - n0), 64'(5));
    pulse_credits(1);
    repeat (4) @(negedge clk);
    chk("starve_6_flits", 64'(nflits - n0), 64'(6));
    drain();

    // Saturating refill, then a credit coincident with the header send.
    pulse_credits(6);
    repeat (2) @(negedge clk);
    n0 = nflits;
    @(negedge clk);
    chk("pkt_ready_idle", 64'(pkt_ready), 64'(1));
    pkt_start = 1;
    pkt_len = 12'd6;
    pkt_dst = 4'd7;
    q.push_back('{3'b001, {12'd6, 4'd7, 16'h0000}});
    for (int i = 1; i < 6; i++) q.push_back('{(i == 5) ? 3'b100 : 3'b010, pay_cnt + 32'(i - 1)});
    @(negedge clk);
    pkt_start = 0;
    @(negedge clk);
    cr_man = 1;
    @(negedge clk);
    cr_man = 0;
    repeat (10) @(negedge clk);
    chk("coincident_5_flits", 64'(nflits - n0), 64'(5));
    pulse_credits(1);
    repeat (4) @(negedge clk);
    chk("coincident_6_flits", 64'(nflits - n0), 64'(6));
    drain();

    // Mid-packet reset during the body.
    auto_credit = 1;
    pulse_credits(4);
    n0 = nflits;
    start_pkt(12'd8, 4'd4, 12'd8);
    for (int i = 0; i < 30 && nflits - n0 < 3; i++) @(negedge clk);
    if (nflits - n0 < 3) expire("mid_body");
    #2 rst = 1;
    #1;
    chk("mid_rst_req", 64'(req), 64'(0));
    chk("mid_rst_flit_valid", 64'(flit_valid), 64'(0));
    chk("mid_rst_flit_id", 64'(flit_id), 64'(0));
    chk("mid_rst_flit_data", 64'(flit_data), 64'(0));
    chk("mid_rst_length", 64'(length), 64'(0));
    chk("mid_rst_pkt_ready", 64'(pkt_ready), 64'(1));
    q.delete();
    repeat (2) @(negedge clk);
    rst = 0;
    p0 = pay_cnt;
    start_pkt(12'd3, 4'd6, 12'd3);
    drain();
    chk("post_rst_payload_words", 64'(pay_cnt - p0), 64'(2));
    repeat (3) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end
endmodule

// File: doc/packet_injector.md
PACKET_INJECTOR -- requirements
Module: packet_injector

Interface
REQ-001 Parameter DATA_W, default 32, flit/payload data width.
REQ-002 Parameter CREDITS, default 4, downstream buffer depth in flits.
REQ-003 Clocking is one clock; reset is asynchronous and active-high.
REQ-004 clk  in  1  rising-edge clock.
REQ-005 rst  in  1  asynchronous active-high reset.
REQ-006 pkt_start  in  1  request to send a new packet; sampled only in IDLE.
REQ-007 pkt_dst  in  4  destination id, latched on accept.
REQ-008 pkt_len  in  12  total flits including header and tail, latched on accept.
REQ-009 pkt_ready  out  1  high only in IDLE.
REQ-010 pay_data  in  DATA_W  payload word.
REQ-011 pay_valid  in  1  payload word available.
REQ-012 pay_ready  out  1  combinational; payload word consumed this cycle.
REQ-013 req  out  1  request to arbiter for this port.
REQ-014 grant  in  1  arbiter grant for this port.
REQ-015 flit_id  out  3  001 header, 010 body, 100 tail; 000 when no flit.
REQ-016 length  out  12  latched packet length, held stable from accept to end of tail.
REQ-017 flit_data  out  DATA_W  flit payload.
REQ-018 flit_valid  out  1  one-cycle pulse per transmitted flit.
REQ-019 credit_in  in  1  one downstream slot freed.

Function
REQ-020 States are IDLE, ARB, SEND.
REQ-021 IDLE, pkt_start=1: latch dst/len, go to ARB next cycle.
REQ-022 Latched length is max(pkt_len,2); values 0 and 1 become 2.
REQ-023 req is registered: high in ARB and SEND, low in IDLE.
REQ-024 ARB to SEND when grant=1.
REQ-025 Send condition, SEND state: grant=1, credit count>0, and (flit index 0, or pay_valid=1).
REQ-026 When the send condition holds, next cycle flit_valid=1 with flit_id and flit_data registered.
REQ-027 Flit index 0 is the header: flit_data = {length, dst, zeros}; no payload consumed.
REQ-028 Indices 1..length-2 are body and index length-1 is the tail; each consumes one payload word (pay_ready=1 that cycle).
REQ-029 Flit index is a 12-bit counter, cleared on accept and incremented per sent flit.
REQ-030 After the tail is sent, go to IDLE; req drops the cycle flit_valid shows the tail.
REQ-031 grant low during SEND (arbiter timeout or preemption): stall, hold index, keep req=1, resume on grant.
REQ-032 pay_valid=0 or credits=0 in SEND: stall, no flit, pay_ready=0.
REQ-033 Credit counter: 0..CREDITS, starts at CREDITS.
REQ-034 Credit counter: minus 1 per sent flit, plus 1 per credit_in.
REQ-035 Credit counter: send and credit_in in the same cycle leave it unchanged.
REQ-036 Credit counter: credit_in at CREDITS is ignored (saturate).
REQ-037 pkt_start outside IDLE is ignored.

Reset
REQ-038 On rst: state IDLE, req=0, flit_valid=0, flit_id=000, flit_data=0, length=0, index=0, credits=CREDITS.
REQ-039 rst mid-packet aborts it; no tail is emitted.

Structure
REQ-040 Shared package holds flit_id encodings (HEADER=001, BODY=010, TAIL=100), state encodings and the header field layout, shared with arbiter and timer.
REQ-041 Sub-module credit_counter (parameter CREDITS; inputs clk, rst, inc, dec; outputs avail and count).

Verification
REQ-042 Base packet, 4 credits: pkt_len=4, dst=3, grant high after 2 cycles, pay_valid constant -> flit_id sequence 001,010,010,100 on consecutive cycles; header carries len 4 and dst 3; req low after tail.
REQ-043 Length clamp: pkt_len=1 -> exactly 2 flits (001,100), length=2, one payload word consumed.
REQ-044 Credit starvation: CREDITS=4, no credit_in, pkt_len=6 -> 4 flits, then stall; each credit_in pulse releases exactly one further flit.
REQ-045 Grant loss: grant drops after the header for 3 cycles -> no flit_valid, req stays 1, index held; resume with body at index 1.
REQ-046 Simultaneous and saturating credits: credit_in coincident with a send keeps count; credit_in at count 4 keeps 4.
REQ-047 Mid-packet reset: rst asserted during body -> outputs take reset values asynchronously; next pkt_start is accepted normally.
